// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
//
// Receive side of a four-channel time-division multiplexed link. Valid beats
// on din carry channels 0,1,2,3 in rotation; frame_sync marks the channel-0
// beat. The framer hunts for a sync beat, then slices each complete frame
// into four parallel channel words that all update on the same cycle.
// Partial frames are never presented on the outputs.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   din         in   [WIDTH-1:0] slot data word
//   din_valid   in   din/frame_sync qualify this cycle (one beat)
//   frame_sync  in   beat is slot 0 of a frame (ignored when din_valid=0)
//   y0..y3      out  [WIDTH-1:0] channel words of the last complete frame
//   out_valid   out  one-cycle pulse, y0..y3 updated this cycle
//   locked      out  framer is in RUN
//   sync_err    out  one-cycle pulse, framing violation detected
//   frame_cnt   out  [7:0] complete frames delivered, wraps 255 -> 0
// ---------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             out_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [7:0]       frame_cnt
);

    localparam logic ST_HUNT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [1:0] SLOT_0 = 2'd0;
    localparam logic [1:0] SLOT_1 = 2'd1;
    localparam logic [1:0] SLOT_2 = 2'd2;
    localparam logic [1:0] SLOT_3 = 2'd3;

    // Framer state
    logic             state_q,     state_d;
    logic [1:0]       slot_q,      slot_d;

    // Shadow registers holding slots 0..2 of the frame being assembled
    logic [WIDTH-1:0] s0_q,        s0_d;
    logic [WIDTH-1:0] s1_q,        s1_d;
    logic [WIDTH-1:0] s2_q,        s2_d;

    // Output registers
    logic [WIDTH-1:0] y0_q,        y0_d;
    logic [WIDTH-1:0] y1_q,        y1_d;
    logic [WIDTH-1:0] y2_q,        y2_d;
    logic [WIDTH-1:0] y3_q,        y3_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q,  sync_err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    // Next-state logic for the framer, shadow registers and outputs
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        y3_d        = y3_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // Beats without sync are discarded silently while hunting
                    if (frame_sync) begin
                        s0_d    = din;
                        slot_d  = SLOT_1;
                        state_d = ST_RUN;
                    end else begin
                        slot_d  = SLOT_0;
                    end
                end

                ST_RUN: begin
                    if (slot_q == SLOT_0) begin
                        if (frame_sync) begin
                            s0_d   = din;
                            slot_d = SLOT_1;
                        end else begin
                            // Expected sync missing: framing lost, drop beat
                            sync_err_d = 1'b1;
                            slot_d     = SLOT_0;
                            state_d    = ST_HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early sync in slot 1..3: abandon the partial frame
                        // but keep this beat as slot 0 of a new frame.
                        sync_err_d = 1'b1;
                        s0_d       = din;
                        slot_d     = SLOT_1;
                    end else begin
                        case (slot_q)
                            SLOT_1: begin
                                s1_d   = din;
                                slot_d = SLOT_2;
                            end
                            SLOT_2: begin
                                s2_d   = din;
                                slot_d = SLOT_3;
                            end
                            SLOT_3: begin
                                // Frame complete: publish all four words at once
                                y0_d        = s0_q;
                                y1_d        = s1_q;
                                y2_d        = s2_q;
                                y3_d        = din;
                                out_valid_d = 1'b1;
                                frame_cnt_d = frame_cnt_q + 8'd1;
                                slot_d      = SLOT_0;
                            end
                            default: begin
                                slot_d = SLOT_0;
                            end
                        endcase
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    slot_d  = SLOT_0;
                end
            endcase
        end else begin
            // No beat this cycle: everything holds, pulses drop
            state_d = state_q;
        end
    end

    // State, shadow and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            slot_q      <= SLOT_0;
            s0_q        <= {WIDTH{1'b0}};
            s1_q        <= {WIDTH{1'b0}};
            s2_q        <= {WIDTH{1'b0}};
            y0_q        <= {WIDTH{1'b0}};
            y1_q        <= {WIDTH{1'b0}};
            y2_q        <= {WIDTH{1'b0}};
            y3_q        <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            y3_q        <= y3_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign y0        = y0_q;
    assign y1        = y1_q;
    assign y2        = y2_q;
    assign y3        = y3_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign frame_cnt = frame_cnt_q;
    // locked is a direct view of the state register, so it is registered too
    assign locked    = (state_q == ST_RUN);

endmodule
